// File: rtl/hazard_pkg.sv
// Shared types and defaults for the MIPS hazard controller and its MDU busy tracker.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  localparam int MDU_LAT_DEFAULT = 4;

endpackage

// File: rtl/mdu_busy_tracker.sv
// Counts down the cycles until an issued mult/div writes HI/LO; busy while nonzero.
module mdu_busy_tracker
  import hazard_pkg::*;
#(
  parameter int LAT = MDU_LAT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic hold,
  output logic busy
);

  logic [3:0] cnt;

  // A held E stage means the op did not really issue; the countdown itself
  // keeps running because the MDU is not frozen by memory waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= '0;
    else if (start && !hold) cnt <= 4'(LAT);
    else if (cnt != '0)      cnt <= cnt - 4'd1;
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_unit_mc.sv
// Pipeline hazard controller: forwarding, load-use/branch/MDU stalls, memory freeze, stall counter.
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int REG_W   = 5,
  parameter int MDU_LAT = MDU_LAT_DEFAULT,
  parameter int CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [REG_W-1:0] rs_d_i,
  input  logic [REG_W-1:0] rt_d_i,
  input  logic [1:0]       branch_d_i,
  input  logic             pc_src_d_i,
  input  logic [2:0]       jump_d_i,
  input  logic             mdu_op_d_i,
  input  logic             hilo_rd_d_i,
  input  logic [REG_W-1:0] rs_e_i,
  input  logic [REG_W-1:0] rt_e_i,
  input  logic [REG_W-1:0] write_reg_e_i,
  input  logic             mem_to_reg_e_i,
  input  logic             reg_write_e_i,
  input  logic             mdu_start_e_i,
  input  logic [REG_W-1:0] write_reg_m_i,
  input  logic             mem_to_reg_m_i,
  input  logic             reg_write_m_i,
  input  logic [REG_W-1:0] write_reg_w_i,
  input  logic             reg_write_w_i,
  input  logic             dmem_wait_i,
  input  logic             perf_clr_i,
  output logic             stall_f_o,
  output logic             stall_d_o,
  output logic             stall_e_o,
  output logic             stall_m_o,
  output logic             flush_d_o,
  output logic             flush_e_o,
  output logic             forward_a_d_o,
  output logic             forward_b_d_o,
  output logic [1:0]       forward_a_e_o,
  output logic [1:0]       forward_b_e_o,
  output logic             hilo_busy_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  function automatic fwd_sel_e fwd_e(input logic [REG_W-1:0] src);
    if (src != '0 && src == write_reg_m_i && reg_write_m_i)      return FWD_MEM;
    else if (src != '0 && src == write_reg_w_i && reg_write_w_i) return FWD_WB;
    else                                                         return FWD_REG;
  endfunction

  assign forward_a_e_o = fwd_e(rs_e_i);
  assign forward_b_e_o = fwd_e(rt_e_i);
  assign forward_a_d_o = (rs_d_i != '0) && (rs_d_i == write_reg_m_i) && reg_write_m_i;
  assign forward_b_d_o = (rt_d_i != '0) && (rt_d_i == write_reg_m_i) && reg_write_m_i;

  logic lw_stall, br_stall, mdu_stall, hz, x_e, x_m;

  assign lw_stall = mem_to_reg_e_i && (write_reg_e_i != '0) &&
                    (rs_d_i == write_reg_e_i || rt_d_i == write_reg_e_i);
  assign x_e = reg_write_e_i && (write_reg_e_i != '0) &&
               (rs_d_i == write_reg_e_i || rt_d_i == write_reg_e_i);
  assign x_m = mem_to_reg_m_i && (write_reg_m_i != '0) &&
               (rs_d_i == write_reg_m_i || rt_d_i == write_reg_m_i);
  assign br_stall = (branch_d_i != '0) && (x_e || x_m);

  mdu_busy_tracker #(.LAT(MDU_LAT)) u_mdu (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .start (mdu_start_e_i),
    .hold  (stall_e_o),
    .busy  (hilo_busy_o)
  );

  // An op issuing in E this cycle already blocks HI/LO users in D.
  assign mdu_stall = (mdu_op_d_i || hilo_rd_d_i) && (hilo_busy_o || mdu_start_e_i);
  assign hz        = lw_stall || br_stall || mdu_stall;

  always_comb begin
    stall_f_o = 1'b0;
    stall_d_o = 1'b0;
    stall_e_o = 1'b0;
    stall_m_o = 1'b0;
    flush_d_o = 1'b0;
    flush_e_o = 1'b0;
    if (dmem_wait_i) begin
      stall_f_o = 1'b1;
      stall_d_o = 1'b1;
      stall_e_o = 1'b1;
      stall_m_o = 1'b1;
    end else begin
      stall_f_o = hz;
      stall_d_o = hz;
      flush_e_o = hz;
      flush_d_o = (pc_src_d_i || jump_d_i != '0) && !hz;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                           stall_cnt_o <= '0;
    else if (perf_clr_i)                   stall_cnt_o <= '0;
    else if (stall_d_o && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
  end

  a_no_issue_while_busy: assert property (
    @(posedge clk_i) disable iff (!rst_ni) !(mdu_start_e_i && hilo_busy_o));

endmodule
